instr_fetch_unit: RTL and testbench

Fetch stage directly upstream of the control unit. It owns the PC, issues one instruction-memory read at a time, and buffers the returned word in a single output slot. From that slot it presents opcode/func3/func7 plus the full instruction and PC to decode. It takes a redirect (branch/jump target resolved downstream) that flushes the slot and discards any in-flight response.

---
 rtl/misc_pkg.sv | 37 +++
 rtl/instr_fetch_unit.sv | 117 +++++++++++
 tb/tb_instr_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/misc_pkg.sv
// Shared fetch/decode definitions: datapath defaults, instruction field positions,
// base opcodes and the fetch FSM state type.
package misc_pkg;

    localparam int unsigned XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    localparam int unsigned OPC_LSB = 0;
    localparam int unsigned OPC_MSB = 6;
    localparam int unsigned F3_LSB  = 12;
    localparam int unsigned F3_MSB  = 14;
    localparam int unsigned F7_LSB  = 25;
    localparam int unsigned F7_MSB  = 31;

    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_LUI    = 7'b011_0111;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;
    localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

    typedef enum logic [1:0] {
        FetchIdle,
        FetchReq,
        FetchWait
    } fetch_state_e;

    // True for opcodes whose outcome may redirect fetch.
    function automatic logic is_control_flow(input logic [6:0] opcode);
        return (opcode == OPC_BRANCH) || (opcode == OPC_JAL) || (opcode == OPC_JALR);
    endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch with a one-entry output slot feeding decode.
// Redirects flush the slot and discard any response still in flight.
module instr_fetch_unit
    import misc_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            rst,

    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,

    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_func3,
    output logic [7:0]      out_func7
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [31:0]     out_instr_q, out_instr_d;

    logic            slot_free;
    logic            req_fire;
    logic [XLEN-1:0] redirect_target;
    logic            unused_redirect_lsbs;

    // Issuing only when the slot is empty or draining guarantees room for the response.
    assign slot_free       = !out_valid_q || out_ready;
    assign imem_req_valid  = (state_q == FetchReq) && slot_free;
    assign imem_req_addr   = pc_q;
    assign req_fire        = imem_req_valid && imem_req_ready;
    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        out_valid_d = out_valid_q && !out_ready;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;

        unique case (state_q)
            FetchIdle: state_d = FetchReq;
            FetchReq: begin
                if (req_fire) begin
                    state_d = FetchWait;
                end
            end
            FetchWait: begin
                if (imem_rsp_valid) begin
                    state_d = FetchReq;
                    if (drop_q) begin
                        drop_d = 1'b0;
                    end else if (!redirect_valid) begin
                        out_valid_d = 1'b1;
                        out_pc_d    = pc_q;
                        out_instr_d = imem_rsp_data;
                        pc_d        = pc_q + XLEN'(4);
                    end
                end
            end
            default: state_d = FetchIdle;
        endcase

        // A request left in flight by the redirect must have its response discarded.
        if (redirect_valid) begin
            out_valid_d = 1'b0;
            pc_d        = redirect_target;
            if (((state_q == FetchWait) && !imem_rsp_valid) ||
                ((state_q == FetchReq) && req_fire)) begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FetchIdle;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_pc     = out_pc_q;
    assign out_instr  = out_instr_q;
    assign out_opcode = out_instr_q[OPC_MSB:OPC_LSB];
    assign out_func3  = out_instr_q[F3_MSB:F3_LSB];
    assign out_func7  = {1'b0, out_instr_q[F7_MSB:F7_LSB]};

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic checked against a
// transaction-level model of the expected fetch and delivery address streams.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;

    logic        a_req_valid, b_req_valid;
    logic [31:0] a_req_addr, b_req_addr;
    logic        a_out_valid, b_out_valid;
    logic [31:0] a_out_pc, b_out_pc;
    logic [31:0] a_out_instr, b_out_instr;
    logic [6:0]  a_opc, b_opc;
    logic [2:0]  a_f3, b_f3;
    logic [7:0]  a_f7, b_f7;

    always #5 clk = ~clk;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut_a (
        .clk(clk), .rst(rst),
        .imem_req_valid(a_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(a_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_out_pc), .out_instr(a_out_instr), .out_opcode(a_opc),
        .out_func3(a_f3), .out_func7(a_f7)
    );

    // Same stimulus, different reset vector: exercises the PC wrap at the top of memory.
    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .rst(rst),
        .imem_req_valid(b_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(b_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_out_pc), .out_instr(b_out_instr), .out_opcode(b_opc),
        .out_func3(b_f3), .out_func7(b_f7)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Memory model: at most one outstanding read, cnt extra cycles before the response.
    bit          pend = 1'b0;
    int          cnt  = 0;
    logic [31:0] pend_addr = '0;
    bit          mem_mode = 1'b1;
    logic [31:0] mem_const = 32'h0000_0013;

    // Reference: next address to be requested and next PC to be delivered to decode.
    logic [31:0] exp_req = '0;
    logic [31:0] exp_out = '0;
    int          n_cons  = 0;

    logic [31:0] hs_log[$];
    logic [31:0] cons_log[$];
    logic [31:0] b_hs_log[$];
    logic [6:0]  last_opc;
    logic [2:0]  last_f3;
    logic [7:0]  last_f7;
    bit          b_seen = 1'b0;
    logic [31:0] b_first_pc = '0;
    logic        obs_req_valid;
    logic [31:0] obs_req_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_mode) return mem_const;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // One clock: drive inputs, settle, run the transaction checks, cross the edge.
    task automatic cycle(input bit rq, input bit ordy, input bit redir,
                         input logic [31:0] tgt, input bit do_rst, input int lat);
        logic [31:0] w;
        bit          hs;
        rst            = do_rst;
        imem_req_ready = rq;
        out_ready      = ordy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        imem_rsp_valid = !do_rst && pend && (cnt == 0);
        imem_rsp_data  = imem_rsp_valid ? mem_word(pend_addr) : 32'hDEAD_BEEF;
        #1;
        obs_req_valid = a_req_valid;
        obs_req_addr  = a_req_addr;
        hs = 1'b0;
        if (b_out_valid && !b_seen) begin
            b_seen     = 1'b1;
            b_first_pc = b_out_pc;
        end
        if (!do_rst) begin
            if (pend) check("req_while_outstanding", 32'(a_req_valid), 32'd0);
            if (a_out_valid && ordy) begin
                w = mem_word(exp_out);
                check("cons_pc", a_out_pc, exp_out);
                check("cons_instr", a_out_instr, w);
                check("cons_opcode", 32'(a_opc), 32'(w[6:0]));
                check("cons_func3", 32'(a_f3), 32'(w[14:12]));
                check("cons_func7", 32'(a_f7), 32'(w[31:25]));
                cons_log.push_back(a_out_pc);
                last_opc = a_opc;
                last_f3  = a_f3;
                last_f7  = a_f7;
                n_cons++;
                exp_out += 32'd4;
            end
            if (a_req_valid && rq) begin
                check("req_addr", a_req_addr, exp_req);
                hs_log.push_back(a_req_addr);
                hs = 1'b1;
                exp_req += 32'd4;
            end
            if (b_req_valid && rq) b_hs_log.push_back(b_req_addr);
            if (redir) begin
                exp_req = tgt & ~32'h3;
                exp_out = tgt & ~32'h3;
            end
        end
        @(posedge clk);
        #1;
        if (do_rst) begin
            pend    = 1'b0;
            cnt     = 0;
            exp_req = '0;
            exp_out = '0;
            b_seen  = 1'b0;
            hs_log.delete();
            cons_log.delete();
            b_hs_log.delete();
        end else begin
            if (imem_rsp_valid) pend = 1'b0;
            else if (pend && cnt > 0) cnt--;
            if (hs) begin
                pend      = 1'b1;
                pend_addr = a_req_addr;
                cnt       = lat;
            end
        end
    endtask

    initial begin
        int n;
        bit rq, ordy, redir, drst;
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;

        // Reset state
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_out_pc", a_out_pc, 32'd0);
        check("rst_out_instr", a_out_instr, 32'd0);
        check("rst_req_valid", 32'(a_req_valid), 32'd0);
        check("rst_b_out_valid", 32'(b_out_valid), 32'd0);

        // Sequential fetch, 1-cycle memory, NOP stream
        cycle(1, 1, 0, 0, 0, 0);
        check("idle_dead_cycle", 32'(obs_req_valid), 32'd0);
        for (int k = 0; k < 40 && cons_log.size() < 3; k++) cycle(1, 1, 0, 0, 0, 0);
        check("seq_timeout", 32'(cons_log.size() >= 3), 32'd1);
        check("seq_req0", hs_log[0], 32'h0);
        check("seq_req1", hs_log[1], 32'h4);
        check("seq_req2", hs_log[2], 32'h8);
        check("seq_out0", cons_log[0], 32'h0);
        check("seq_out1", cons_log[1], 32'h4);
        check("seq_out2", cons_log[2], 32'h8);
        check("nop_opcode", 32'(last_opc), 32'h13);
        check("nop_func3", 32'(last_f3), 32'h0);
        check("nop_func7", 32'(last_f7), 32'h0);
        check("wrap_first_pc", b_first_pc, 32'hFFFF_FFFC);
        check("wrap_next_req", b_hs_log[1], 32'h0000_0000);

        // Back-pressure: slot held for 5 cycles, no new request
        cycle(0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 20 && !a_out_valid; k++) cycle(1, 0, 0, 0, 0, 0);
        check("stall_timeout", 32'(a_out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            cycle(1, 0, 0, 0, 0, 0);
            check("stall_valid", 32'(a_out_valid), 32'd1);
            check("stall_pc", a_out_pc, 32'h0);
            check("stall_instr", a_out_instr, 32'h13);
            check("stall_no_req", 32'(obs_req_valid), 32'd0);
        end
        cycle(1, 1, 0, 0, 0, 0);
        check("resume_req_valid", 32'(obs_req_valid), 32'd1);
        check("resume_req_addr", obs_req_addr, 32'h4);

        // Redirect while waiting on the response for 0x8
        mem_mode = 1'b0;
        cycle(0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 60 && hs_log.size() < 3; k++) cycle(1, 1, 0, 0, 0, 1);
        check("wait_redirect_setup", 32'(pend && cnt != 0 && hs_log.size() == 3), 32'd1);
        n = cons_log.size();
        cycle(1, 1, 1, 32'h103, 0, 1);
        for (int k = 0; k < 10 && hs_log.size() < 4; k++) begin
            cycle(1, 1, 0, 0, 0, 1);
            check("wait_redirect_slot_empty", 32'(a_out_valid), 32'd0);
        end
        check("wait_redirect_req", hs_log[3], 32'h100);
        for (int k = 0; k < 10 && cons_log.size() <= n; k++) cycle(1, 1, 0, 0, 0, 1);
        check("wait_redirect_out", cons_log[n], 32'h100);

        // Redirect coinciding with the response
        for (int k = 0; k < 20 && !(pend && cnt == 0); k++) cycle(1, 1, 0, 0, 0, 1);
        check("rsp_redirect_setup", 32'(pend && cnt == 0), 32'd1);
        cycle(1, 1, 1, 32'h200, 0, 1);
        n = cons_log.size();
        check("rsp_redirect_slot", 32'(a_out_valid), 32'd0);
        cycle(1, 1, 0, 0, 0, 1);
        check("rsp_redirect_req_valid", 32'(obs_req_valid), 32'd1);
        check("rsp_redirect_req_addr", obs_req_addr, 32'h200);
        for (int k = 0; k < 10 && cons_log.size() <= n; k++) cycle(1, 1, 0, 0, 0, 1);
        check("rsp_redirect_out", cons_log[n], 32'h200);

        // R-type decode fields, then reset in the middle of a wait
        mem_mode  = 1'b1;
        mem_const = 32'h40B5_0533;
        cycle(0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 20 && cons_log.size() < 1; k++) cycle(1, 1, 0, 0, 0, 1);
        check("sub_opcode", 32'(last_opc), 32'h33);
        check("sub_func3", 32'(last_f3), 32'h0);
        check("sub_func7", 32'(last_f7), 32'h20);
        for (int k = 0; k < 20 && !(pend && cnt != 0); k++) cycle(1, 1, 0, 0, 0, 1);
        check("mid_rst_setup", 32'(pend && cnt != 0), 32'd1);
        cycle(1, 1, 0, 0, 1, 1);
        check("mid_rst_out_valid", 32'(a_out_valid), 32'd0);
        check("mid_rst_req_valid", 32'(a_req_valid), 32'd0);
        for (int k = 0; k < 10 && hs_log.size() < 1; k++) cycle(1, 1, 0, 0, 0, 1);
        check("mid_rst_restart", hs_log[0], 32'h0);

        // Random traffic against the transaction model
        mem_mode = 1'b0;
        n_cons   = 0;
        for (int k = 0; k < 3000; k++) begin
            rq    = ($urandom_range(0, 3) != 0);
            ordy  = ($urandom_range(0, 2) != 0);
            redir = ($urandom_range(0, 15) == 0);
            drst  = ($urandom_range(0, 499) == 0);
            cycle(rq, ordy, redir, $urandom, drst, int'($urandom_range(0, 3)));
        end
        check("random_progress", 32'(n_cons > 50), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
